gmii_rx_monitor: RTL and testbench



---
 rtl/gmii_rx_monitor_if.sv | 31 +++
 rtl/gmii_rx_monitor.sv | 165 ++++++++++++++++
 tb/tb_gmii_rx_monitor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_monitor_if.sv
// GMII receive tap plus per-frame result and statistics bundle for gmii_rx_monitor.
// The master side drives the GMII stream and clear; the slave side is the monitor.
interface gmii_rx_monitor_if #(
    parameter int CW = 16
);
    logic [7:0]    rxd;
    logic          rx_dv;
    logic          rx_er;
    logic          clear;
    logic          frame_done;
    logic [2:0]    frame_status;
    logic [15:0]   frame_len;
    logic [CW-1:0] cnt_good;
    logic [CW-1:0] cnt_crc;
    logic [CW-1:0] cnt_rxer;
    logic [CW-1:0] cnt_runt;
    logic [CW-1:0] cnt_over;
    logic [CW-1:0] cnt_pre;

    modport master (
        output rxd, rx_dv, rx_er, clear,
        input  frame_done, frame_status, frame_len,
        input  cnt_good, cnt_crc, cnt_rxer, cnt_runt, cnt_over, cnt_pre
    );

    modport slave (
        input  rxd, rx_dv, rx_er, clear,
        output frame_done, frame_status, frame_len,
        output cnt_good, cnt_crc, cnt_rxer, cnt_runt, cnt_over, cnt_pre
    );
endinterface

// File: rtl/gmii_rx_monitor.sv
// Passive GMII receive monitor: preamble/SFD parsing, on-the-fly CRC-32 check,
// per-frame classification and saturating per-class frame counters.
module gmii_rx_monitor #(
    parameter int CW      = 16,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic              clk,
    input  logic              rstn,
    gmii_rx_monitor_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam int          NCLS        = 6;

    localparam logic [2:0] CLS_GOOD = 3'd0;
    localparam logic [2:0] CLS_CRC  = 3'd1;
    localparam logic [2:0] CLS_RXER = 3'd2;
    localparam logic [2:0] CLS_RUNT = 3'd3;
    localparam logic [2:0] CLS_OVER = 3'd4;
    localparam logic [2:0] CLS_PRE  = 3'd5;

    state_t        r_state;
    logic          r_dv_prev;
    logic [31:0]   r_crc;
    logic [15:0]   r_len;
    logic          r_err;
    logic          r_done;
    logic [2:0]    r_status;
    logic [15:0]   r_flen;
    logic [CW-1:0] r_cnt [NCLS];

    state_t        w_state_next;
    logic [31:0]   w_crc_next;
    logic [15:0]   w_len_next;
    logic          w_err_next;
    logic          w_eof;
    logic [2:0]    w_class;

    // Reflected CRC-32, one byte per call, data consumed LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY_R;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_dv_prev <= 1'b1;
            r_crc     <= 32'hFFFF_FFFF;
            r_len     <= 16'd0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_dv_prev <= bus.rx_dv;
            r_crc     <= w_crc_next;
            r_len     <= w_len_next;
            r_err     <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_crc_next   = r_crc;
        w_len_next   = r_len;
        w_err_next   = r_err;
        w_eof        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rx_dv && !r_dv_prev) begin
                    w_err_next   = 1'b0;
                    w_len_next   = 16'd0;
                    w_state_next = (bus.rxd == PRE_BYTE) ? S_PRE : S_DROP;
                end
            end
            S_PRE: begin
                if (!bus.rx_dv) begin
                    w_eof        = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_err_next = r_err | bus.rx_er;
                    if (bus.rxd == SFD_BYTE) begin
                        w_state_next = S_DATA;
                        w_crc_next   = 32'hFFFF_FFFF;
                        w_len_next   = 16'd0;
                    end else if (bus.rxd != PRE_BYTE) begin
                        w_state_next = S_DROP;
                    end
                end
            end
            S_DATA: begin
                if (!bus.rx_dv) begin
                    w_eof        = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_err_next = r_err | bus.rx_er;
                    w_crc_next = crc32_byte(r_crc, bus.rxd);
                    if (r_len != 16'hFFFF) w_len_next = r_len + 16'd1;
                end
            end
            default: begin
                if (!bus.rx_dv) begin
                    w_eof        = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_err_next = r_err | bus.rx_er;
                end
            end
        endcase
    end

    // Any frame ending outside DATA never saw a valid SFD, so it is a preamble error.
    always_comb begin
        w_class = CLS_GOOD;
        if (r_state != S_DATA)                  w_class = CLS_PRE;
        else if (r_err)                         w_class = CLS_RXER;
        else if (32'(r_len) < MIN_LEN)          w_class = CLS_RUNT;
        else if (32'(r_len) > MAX_LEN)          w_class = CLS_OVER;
        else if (r_crc != CRC_RESIDUE)          w_class = CLS_CRC;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_done   <= 1'b0;
            r_status <= 3'd0;
            r_flen   <= 16'd0;
        end else begin
            r_done <= w_eof;
            if (w_eof) begin
                r_status <= w_class;
                r_flen   <= r_len;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCLS; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!rstn || bus.clear)
                    r_cnt[gi] <= '0;
                else if (w_eof && (w_class == 3'(gi)) && (r_cnt[gi] != {CW{1'b1}}))
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
    endgenerate

    assign bus.frame_done   = r_done;
    assign bus.frame_status = r_status;
    assign bus.frame_len    = r_flen;
    assign bus.cnt_good     = r_cnt[CLS_GOOD];
    assign bus.cnt_crc      = r_cnt[CLS_CRC];
    assign bus.cnt_rxer     = r_cnt[CLS_RXER];
    assign bus.cnt_runt     = r_cnt[CLS_RUNT];
    assign bus.cnt_over     = r_cnt[CLS_OVER];
    assign bus.cnt_pre      = r_cnt[CLS_PRE];
endmodule

// File: tb/tb_gmii_rx_monitor.sv
// Directed bench for gmii_rx_monitor: frame classes, boundaries, saturation, clear, reset.
// Frames are built with a bench-side CRC-32 so FCS values are generated, not read back.
module tb_gmii_rx_monitor;
    localparam int CW = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #4 clk = ~clk;

    gmii_rx_monitor_if #(.CW(CW)) bus ();

    gmii_rx_monitor #(.CW(CW), .MIN_LEN(64), .MAX_LEN(1522)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total  = 0;
    int bad    = 0;
    int n_done = 0;
    int d0;
    logic [7:0] tx [$];

    // frame_done is sampled at the edge that ends its cycle, so counts settle by the next negedge.
    always @(posedge clk) if (bus.frame_done) n_done++;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Preamble + SFD + len bytes (DA..FCS); flip >= 0 corrupts that frame byte after FCS is fixed.
    task automatic build(input int len, input int flip);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        tx.delete();
        repeat (7) tx.push_back(8'h55);
        tx.push_back(8'hD5);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < len - 4; i++) begin
            b = 8'(i * 37 + 11);
            tx.push_back(b);
            crc = crc_upd(crc, b);
        end
        fcs = ~crc;
        tx.push_back(fcs[7:0]);
        tx.push_back(fcs[15:8]);
        tx.push_back(fcs[23:16]);
        tx.push_back(fcs[31:24]);
        if (flip >= 0) tx[8 + flip] = tx[8 + flip] ^ 8'h01;
    endtask

    // Called at a negedge; returns at the negedge where frame_done should be visible.
    task automatic send(input int er_idx, input logic clr_at_end);
        foreach (tx[i]) begin
            bus.rx_dv = 1'b1;
            bus.rxd   = tx[i];
            bus.rx_er = (i == er_idx);
            @(negedge clk);
        end
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        bus.rxd   = 8'h00;
        bus.clear = clr_at_end;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int st, input int len);
        $display("frame %s: done=%0b status=%0d len=%0d", tag, bus.frame_done, bus.frame_status, bus.frame_len);
        check({tag, "_done"}, 32'(bus.frame_done), 32'd1);
        check({tag, "_status"}, 32'(bus.frame_status), 32'(st));
        if (len >= 0) check({tag, "_len"}, 32'(bus.frame_len), 32'(len));
    endtask

    task automatic check_cnts(input string tag, input int g, input int c, input int e,
                              input int r, input int o, input int p);
        check({tag, "_cnt_good"}, 32'(bus.cnt_good), 32'(g));
        check({tag, "_cnt_crc"},  32'(bus.cnt_crc),  32'(c));
        check({tag, "_cnt_rxer"}, 32'(bus.cnt_rxer), 32'(e));
        check({tag, "_cnt_runt"}, 32'(bus.cnt_runt), 32'(r));
        check({tag, "_cnt_over"}, 32'(bus.cnt_over), 32'(o));
        check({tag, "_cnt_pre"},  32'(bus.cnt_pre),  32'(p));
    endtask

    initial begin
        bus.rxd   = 8'h00;
        bus.rx_dv = 1'b0;
        bus.rx_er = 1'b0;
        bus.clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(bus.frame_done), 32'd0);
        check("rst_status", 32'(bus.frame_status), 32'd0);
        check("rst_len", 32'(bus.frame_len), 32'd0);
        check_cnts("rst", 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        @(negedge clk);

        build(64, -1);   send(-1, 1'b0);
        check_frame("good64", 0, 64);
        check_cnts("good64", 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus.frame_done), 32'd0);
        check("status_hold", 32'(bus.frame_status), 32'd0);

        build(64, 20);   send(-1, 1'b0);
        check_frame("crcerr", 1, 64);
        check_cnts("crcerr", 1, 1, 0, 0, 0, 0);

        build(63, -1);   send(-1, 1'b0);
        check_frame("runt63", 3, 63);
        check_cnts("runt63", 1, 1, 0, 1, 0, 0);

        build(1523, -1); send(-1, 1'b0);
        check_frame("over1523", 4, 1523);
        check_cnts("over1523", 1, 1, 0, 1, 1, 0);

        build(1522, -1); send(-1, 1'b0);
        check_frame("max1522", 0, 1522);
        check_cnts("max1522", 2, 1, 0, 1, 1, 0);

        build(64, -1);   send(8 + 30, 1'b0);
        check_frame("rxer", 2, 64);
        check_cnts("rxer", 2, 1, 1, 1, 1, 0);

        tx.delete();
        repeat (7) tx.push_back(8'h55);
        tx.push_back(8'h12);
        repeat (4) tx.push_back(8'hA5);
        send(-1, 1'b0);
        check_frame("badsfd", 5, -1);
        check_cnts("badsfd", 2, 1, 1, 1, 1, 1);

        tx.delete();
        tx.push_back(8'hD5);
        repeat (6) tx.push_back(8'h55);
        send(-1, 1'b0);
        check_frame("first_d5", 5, -1);
        check_cnts("first_d5", 2, 1, 1, 1, 1, 2);

        // False carrier in idle must not start a frame.
        @(negedge clk);
        d0 = n_done;
        bus.rx_er = 1'b1;
        repeat (5) @(negedge clk);
        bus.rx_er = 1'b0;
        repeat (3) @(negedge clk);
        check("false_carrier_done", 32'(n_done - d0), 32'd0);
        check_cnts("false_carrier", 2, 1, 1, 1, 1, 2);

        build(64, -1);   send(-1, 1'b1);
        check_frame("clear_on_done", 0, 64);
        check_cnts("clear_on_done", 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        d0 = n_done;
        repeat (20) begin
            build(64, -1);
            send(-1, 1'b0);
        end
        check("sat_status", 32'(bus.frame_status), 32'd0);
        @(negedge clk);
        check("sat_strobes", 32'(n_done - d0), 32'd20);
        check("sat_cnt_good", 32'(bus.cnt_good), 32'd15);
        $display("saturation: strobes=%0d cnt_good=%0d", n_done - d0, bus.cnt_good);

        @(negedge clk);
        d0 = n_done;
        build(64, -1);
        foreach (tx[i]) begin
            if (i == 28) rstn = 1'b0;
            if (i == 30) rstn = 1'b1;
            bus.rx_dv = 1'b1;
            bus.rxd   = tx[i];
            @(negedge clk);
        end
        bus.rx_dv = 1'b0;
        bus.rxd   = 8'h00;
        repeat (4) @(negedge clk);
        $display("reset mid-frame: strobes=%0d", n_done - d0);
        check("rstmid_strobes", 32'(n_done - d0), 32'd0);
        check_cnts("rstmid", 0, 0, 0, 0, 0, 0);

        build(64, -1);   send(-1, 1'b0);
        check_frame("after_rst", 0, 64);
        check_cnts("after_rst", 1, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
